chunked_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor. It is the responder end of the start/done handshake that the modular adder issues.
- Processes CHUNK bits per clock, LSB chunk first, with a registered carry. This bounds the carry-chain length for timing closure.
- Returns a (WIDTH+1)-bit result. The MSB is the raw carry-out, which downstream modular reduction uses to select its output.

---
 rtl/chunked_adder.sv | 150 +++++++++++++++
 tb/tb_chunked_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Latency: done is high in the cycle after edge t0+NCHUNK, or after edge t0+1 with
//   CHUNKED_ADDER_SINGLE_CYCLE_EN defined. One operation per latency+1 cycles.
// Backpressure: none. start is ignored while busy, and start during the done cycle is accepted.
//
// Ports:
//   clk, reset           rising-edge clock; asynchronous active-high reset
//   start, subtract      request; subtract=1 computes a + ~b + 1 (sampled with start)
//   in_a, in_b           WIDTH-bit operands, registered on the accepting edge
//   result               [WIDTH-1:0] sum/difference mod 2^WIDTH, [WIDTH] raw carry-out
//   done                 one-cycle pulse, result valid
//   busy                 high while an operation is in progress
// Optional macro: CHUNKED_ADDER_SINGLE_CYCLE_EN does the full-width add in a single RUN edge.
module chunked_adder #(
  parameter int WIDTH = 384,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

`ifdef CHUNKED_ADDER_SINGLE_CYCLE_EN
  logic [WIDTH:0]   full_sum;
`else
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
`endif

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
`ifdef CHUNKED_ADDER_SINGLE_CYCLE_EN
    full_sum = '0;
`else
    cnt_d     = cnt_q;
    a_chunk   = '0;
    b_chunk   = '0;
    chunk_sum = '0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is folded into the add: store ~b and seed the carry with 1.
          opa_d   = in_a;
          opb_d   = subtract ? ~in_b : in_b;
          carry_d = subtract;
`ifndef CHUNKED_ADDER_SINGLE_CYCLE_EN
          cnt_d   = '0;
`endif
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
`ifdef CHUNKED_ADDER_SINGLE_CYCLE_EN
        full_sum = {1'b0, opa_q} + {1'b0, opb_q} + (WIDTH+1)'(carry_q);
        result_d = full_sum;
        carry_d  = full_sum[WIDTH];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
`else
        // Constant-index mux keeps the slice selects static and narrow.
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CW'(k)) begin
            a_chunk = opa_q[k*CHUNK +: CHUNK];
            b_chunk = opb_q[k*CHUNK +: CHUNK];
          end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CW'(k)) begin
            result_d[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
          end
        end
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCHUNK-1)) begin
          result_d[WIDTH] = chunk_sum[CHUNK];
          done_d          = 1'b1;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifndef CHUNKED_ADDER_SINGLE_CYCLE_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifndef CHUNKED_ADDER_SINGLE_CYCLE_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: self-checking bench for chunked_adder (default and single-cycle builds).
// Latency: expected done cycle is the start edge plus LAT, tracked per operation.
// Backpressure: exercises start while busy and start held through the done cycle.
module tb_chunked_adder;

  localparam int W   = 384;
  localparam int CH  = 64;
  localparam int NCH = W / CH;
  localparam int RW  = W + 1;
`ifdef CHUNKED_ADDER_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = NCH;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          subtract;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [W:0]    result;
  logic          done;
  logic          busy;

  chunked_adder #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: subtraction as a + ~b + 1 over WIDTH+1 bits, so bit WIDTH is the no-borrow flag.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + RW'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Scoreboard: every done must match the oldest outstanding operation, in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", RW'(done), RW'(0));
      end else begin
        e = sb.pop_front();
        check_val("result", result, e.res);
        check_val("latency", RW'(cyc), RW'(e.cyc));
      end
    end
  end

  // Drives one accepted request; returns #1 after the accepting edge with operands scrambled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    in_a     = a;
    in_b     = b;
    subtract = sub;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{model(a, b, sub), cyc + LAT});
    in_a     = ~a;
    in_b     = ~b;
    subtract = ~sub;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", RW'(sb.size()), RW'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ones;
    int npulse;
    ones     = '1;
    npulse   = (LAT > 1) ? 2 : 1;
    reset    = 1'b1;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;

    #1;
    check_val("reset_result", result, RW'(0));
    check_val("reset_done", RW'(done), RW'(0));
    check_val("reset_busy", RW'(busy), RW'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic add with busy/done timing.
    issue(W'(5), W'(3), 1'b0);
    for (int i = 0; i < LAT; i++) begin
      check_val("busy_run", RW'(busy), RW'(1));
      @(posedge clk);
      #1;
    end
    check_val("busy_after", RW'(busy), RW'(0));
    check_val("done_pulse", RW'(done), RW'(1));
    check_val("basic_add", result, RW'(8));
    @(posedge clk);
    #1;
    check_val("done_cleared", RW'(done), RW'(0));
    check_val("result_hold", result, RW'(8));
    wait_drain();

    // Carry propagation and sign/borrow corners.
    issue(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0);
    wait_drain();
    check_val("inter_chunk", result, RW'(1) << 64);
    issue(ones, W'(1), 1'b0);
    wait_drain();
    check_val("full_overflow", result, RW'(1) << W);
    issue(W'(5), W'(3), 1'b1);
    wait_drain();
    check_val("sub_no_borrow", result, (RW'(1) << W) | RW'(2));
    issue(W'(3), W'(5), 1'b1);
    wait_drain();
    check_val("sub_borrow", result, {1'b0, ones - W'(1)});

    for (int i = 0; i < 6; i++) begin
      issue(rand_word(), rand_word(), i[0]);
      wait_drain();
    end

    // start while busy is ignored.
    issue(W'(7), W'(1), 1'b0);
    in_a     = W'(100);
    in_b     = W'(1);
    subtract = 1'b0;
    start    = 1'b1;
    repeat (npulse) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain();
    check_val("ignored_start", result, RW'(8));
    repeat (LAT + 3) @(negedge clk);
    check_val("ignored_busy", RW'(busy), RW'(0));

    // start during the done cycle is accepted back-to-back.
    issue(W'(10), W'(20), 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) break;
    end
    issue(W'(2), W'(2), 1'b0);
    check_val("b2b_busy", RW'(busy), RW'(1));
    wait_drain();
    check_val("b2b_result", result, RW'(4));

    // Reset mid-operation abandons the op.
    issue(W'(9), W'(9), 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_val("mid_reset_result", result, RW'(0));
    check_val("mid_reset_done", RW'(done), RW'(0));
    check_val("mid_reset_busy", RW'(busy), RW'(0));
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    issue(W'(1), W'(1), 1'b0);
    wait_drain();
    check_val("post_reset_add", result, RW'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
